// File: rtl/sdram_pll_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sdram_pll_supervisor
//  Description : Sequences the SDRAM PLL reset, waits for a stable lock, and
//                only then releases the SDRAM-domain reset. It retries on lock
//                timeout, goes to a sticky fail state when retries run out, and
//                re-runs the sequence if lock is lost.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_pll_supervisor #(
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int STABLE_CYC       = 1024,
    parameter int MAX_RETRIES      = 7,
    parameter int SYNC_STAGES      = 2
) (
    input  logic       i_refclk,
    input  logic       i_rst_n,
    input  logic       i_pll_locked,
    input  logic       i_restart,
    output logic       o_pll_rst,
    output logic       o_sys_rst_n,
    output logic       o_ready,
    output logic       o_lock_lost,
    output logic       o_fail,
    output logic [3:0] o_retry_cnt
);

    // One counter is shared by every timed state, so size it for the longest.
    localparam int c_CNT_MAX_A = (LOCK_TIMEOUT_CYC > STABLE_CYC) ? LOCK_TIMEOUT_CYC : STABLE_CYC;
    localparam int c_CNT_MAX   = (c_CNT_MAX_A > PLL_RST_CYC) ? c_CNT_MAX_A : PLL_RST_CYC;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_PLLRST_END  = c_CNT_W'(PLL_RST_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_END = c_CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_END  = c_CNT_W'(STABLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT     = {c_CNT_W{1'b1}};
    localparam logic [3:0]         c_MAX_RETRIES = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLLRST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_s;
    logic [3:0]             r_retry;
    logic [3:0]             w_retry_nxt;
    logic                   w_lock_lost_nxt;
    logic                   r_pll_rst;
    logic                   r_sys_rst_n;
    logic                   r_ready;
    logic                   r_lock_lost;
    logic                   r_fail;

    // Bring the asynchronous PLL locked flag into the refclk domain.
    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pll_locked};
        end
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // Next-state, counter and retry logic; restart overrides everything else.
    always_comb begin
        w_state_nxt     = r_state;
        w_retry_nxt     = r_retry;
        w_lock_lost_nxt = 1'b0;
        w_cnt_nxt       = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + 1'b1;
        if (i_restart) begin
            w_state_nxt = ST_PLLRST;
            w_retry_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_PLLRST: begin
                    if (r_cnt == c_PLLRST_END) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout.
                    if (w_locked_s) begin
                        w_state_nxt = ST_STABLE;
                    end else if (r_cnt == c_TIMEOUT_END) begin
                        if (r_retry < c_MAX_RETRIES) begin
                            w_retry_nxt = r_retry + 4'd1;
                            w_state_nxt = ST_PLLRST;
                        end else begin
                            w_state_nxt = ST_FAIL;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end else if (r_cnt == c_STABLE_END) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = 4'd0;
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        w_state_nxt     = ST_PLLRST;
                        w_lock_lost_nxt = 1'b1;
                    end
                end
                ST_FAIL: begin
                    w_state_nxt = ST_FAIL;
                end
                default: begin
                    w_state_nxt = ST_PLLRST;
                end
            endcase
        end
        // A restart in PLLRST keeps the state but must still restart the count.
        if (i_restart || (w_state_nxt != r_state)) begin
            w_cnt_nxt = '0;
        end
    end

    // State, counter and registered outputs, all decoded from the next state.
    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_PLLRST;
            r_cnt       <= '0;
            r_retry     <= 4'd0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_pll_rst   <= (w_state_nxt == ST_PLLRST);
            r_sys_rst_n <= (w_state_nxt == ST_RUN);
            r_ready     <= (w_state_nxt == ST_RUN);
            r_lock_lost <= w_lock_lost_nxt;
            r_fail      <= (w_state_nxt == ST_FAIL);
        end
    end

    assign o_pll_rst   = r_pll_rst;
    assign o_sys_rst_n = r_sys_rst_n;
    assign o_ready     = r_ready;
    assign o_lock_lost = r_lock_lost;
    assign o_fail      = r_fail;
    assign o_retry_cnt = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_sdram_pll_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_pll_supervisor
//  Description : Event scoreboard bench for sdram_pll_supervisor. Stimulus
//                queues each expected output change with the refclk cycle it
//                must appear on; a monitor pops and checks every change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_pll_supervisor;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       o_pll_rst;
    logic       o_sys_rst_n;
    logic       o_ready;
    logic       o_lock_lost;
    logic       o_fail;
    logic [3:0] o_retry_cnt;

    sdram_pll_supervisor #(
        .PLL_RST_CYC      (4),
        .LOCK_TIMEOUT_CYC (100),
        .STABLE_CYC       (8),
        .MAX_RETRIES      (3),
        .SYNC_STAGES      (2)
    ) u_dut (
        .i_refclk     (refclk),
        .i_rst_n      (rst_n),
        .i_pll_locked (pll_locked),
        .i_restart    (restart),
        .o_pll_rst    (o_pll_rst),
        .o_sys_rst_n  (o_sys_rst_n),
        .o_ready      (o_ready),
        .o_lock_lost  (o_lock_lost),
        .o_fail       (o_fail),
        .o_retry_cnt  (o_retry_cnt)
    );

    typedef struct {
        int         c;
        logic [8:0] v;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [8:0] last;
    logic [8:0] cur;

    assign cur = {o_pll_rst, o_sys_rst_n, o_ready, o_lock_lost, o_fail, o_retry_cnt};

    // 50 MHz reference clock.
    initial forever #10 refclk = ~refclk;

    // Cycle stamp: number of rising edges seen so far.
    always @(posedge refclk) cyc <= cyc + 1;

    // Output vector {pll_rst, sys_rst_n, ready, lock_lost, fail, retry_cnt}.
    function automatic logic [8:0] ev(bit p, bit s, bit r, bit l, bit f, logic [3:0] rc);
        return {p, s, r, l, f, rc};
    endfunction

    task automatic push(int c, logic [8:0] v);
        exp_t e;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic at_cyc(int c);
        while (cyc < c) @(negedge refclk);
    endtask

    task automatic chk(string name, logic [8:0] exp);
        total++;
        if (cur !== exp) begin
            bad++;
            $display("FAIL %s: got=%b required=%b (cycle %0d)", name, cur, exp, cyc);
        end
    endtask

    // Monitor: every output change must match the head of the queue, value and cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge refclk);
            if (mon_en && (cur !== last)) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: cycle=%0d got=%b required=no change", cyc, cur);
                end else begin
                    e = q.pop_front();
                    if ((e.v !== cur) || (e.c != cyc)) begin
                        bad++;
                        $display("FAIL event: got=%b at cycle %0d required=%b at cycle %0d",
                                 cur, cyc, e.v, e.c);
                    end
                end
            end
            last = cur;
        end
    end

    // Hard stop if the run ever stalls.
    initial begin
        #60000;
        $display("FAIL watchdog: simulation exceeded 3000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int r;

        // Reset values while rst_n is held low.
        at_cyc(2);
        chk("reset_values", ev(1, 0, 0, 0, 0, 4'd0));

        // 1: release, lock 10 cycles after pll_rst falls, release 11 cycles later.
        at_cyc(3);
        b = cyc;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        push(b + 4, ev(0, 0, 0, 0, 0, 4'd0));
        at_cyc(b + 14);
        pll_locked = 1'b1;
        push(b + 25, ev(0, 1, 1, 0, 0, 4'd0));
        at_cyc(b + 30);

        // 4: lock loss in RUN, lock_lost pulse, fresh PLL reset, relock.
        b = cyc;
        pll_locked = 1'b0;
        push(b + 3, ev(1, 0, 0, 1, 0, 4'd0));
        push(b + 4, ev(1, 0, 0, 0, 0, 4'd0));
        push(b + 7, ev(0, 0, 0, 0, 0, 4'd0));
        at_cyc(b + 12);
        pll_locked = 1'b1;
        push(b + 23, ev(0, 1, 1, 0, 0, 4'd0));
        at_cyc(b + 28);

        // 5b + 3: restart in RUN (no lock_lost), then a short lock aborted in STABLE.
        b = cyc;
        restart    = 1'b1;
        pll_locked = 1'b0;
        push(b + 1, ev(1, 0, 0, 0, 0, 4'd0));
        push(b + 5, ev(0, 0, 0, 0, 0, 4'd0));
        at_cyc(b + 1);
        restart = 1'b0;
        at_cyc(b + 10);
        pll_locked = 1'b1;
        at_cyc(b + 15);
        pll_locked = 1'b0;
        at_cyc(b + 25);
        pll_locked = 1'b1;
        push(b + 36, ev(0, 1, 1, 0, 0, 4'd0));
        at_cyc(b + 40);

        // 2: lock never returns -> retries 1,2,3 then sticky fail.
        b = cyc;
        pll_locked = 1'b0;
        push(b + 3,   ev(1, 0, 0, 1, 0, 4'd0));
        push(b + 4,   ev(1, 0, 0, 0, 0, 4'd0));
        push(b + 7,   ev(0, 0, 0, 0, 0, 4'd0));
        push(b + 107, ev(1, 0, 0, 0, 0, 4'd1));
        push(b + 111, ev(0, 0, 0, 0, 0, 4'd1));
        push(b + 211, ev(1, 0, 0, 0, 0, 4'd2));
        push(b + 215, ev(0, 0, 0, 0, 0, 4'd2));
        push(b + 315, ev(1, 0, 0, 0, 0, 4'd3));
        push(b + 319, ev(0, 0, 0, 0, 0, 4'd3));
        push(b + 419, ev(0, 0, 0, 0, 1, 4'd3));
        at_cyc(b + 700);
        chk("fail_held", ev(0, 0, 0, 0, 1, 4'd3));

        // 5a: restart out of FAIL, then lock to RUN.
        b = cyc;
        restart = 1'b1;
        push(b + 1, ev(1, 0, 0, 0, 0, 4'd0));
        push(b + 5, ev(0, 0, 0, 0, 0, 4'd0));
        at_cyc(b + 1);
        restart = 1'b0;
        at_cyc(b + 8);
        pll_locked = 1'b1;
        push(b + 19, ev(0, 1, 1, 0, 0, 4'd0));
        at_cyc(b + 24);

        // 6a: async reset while in STABLE.
        b = cyc;
        restart = 1'b1;
        push(b + 1, ev(1, 0, 0, 0, 0, 4'd0));
        push(b + 5, ev(0, 0, 0, 0, 0, 4'd0));
        at_cyc(b + 1);
        restart = 1'b0;
        at_cyc(b + 8);
        mon_en = 1'b0;
        #3 rst_n = 1'b0;
        #1 chk("async_reset_stable", ev(1, 0, 0, 0, 0, 4'd0));
        at_cyc(b + 11);
        r = cyc;
        rst_n = 1'b1;
        push(r + 4,  ev(0, 0, 0, 0, 0, 4'd0));
        push(r + 13, ev(0, 1, 1, 0, 0, 4'd0));
        at_cyc(r + 1);
        mon_en = 1'b1;
        at_cyc(r + 18);

        // 6b: async reset while in PLLRST; the count must restart from zero.
        b = cyc;
        restart = 1'b1;
        push(b + 1, ev(1, 0, 0, 0, 0, 4'd0));
        at_cyc(b + 1);
        restart = 1'b0;
        at_cyc(b + 2);
        mon_en = 1'b0;
        #3 rst_n = 1'b0;
        #1 chk("async_reset_pllrst", ev(1, 0, 0, 0, 0, 4'd0));
        at_cyc(b + 5);
        r = cyc;
        rst_n = 1'b1;
        push(r + 4,  ev(0, 0, 0, 0, 0, 4'd0));
        push(r + 13, ev(0, 1, 1, 0, 0, 4'd0));
        at_cyc(r + 1);
        mon_en = 1'b1;
        at_cyc(r + 20);

        // Every queued event must have been seen.
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending_events=%0d required=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
